// File: rtl/tetris_line_clear.sv
// rtl/tetris_line_clear.sv - removes full rows from a playfield snapshot and keeps line/level statistics
module tetris_line_clear #(
  parameter int ROWS            = 21,
  parameter int COLS            = 10,
  parameter int CW              = 3,
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 15
) (
  input  logic                                clk,
  input  logic                                nRst_i,
  input  logic                                start_i,
  input  logic [ROWS-1:0][COLS-1:0][CW-1:0]   grid_i,
  input  logic                                clr_stats_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic [ROWS-1:0][COLS-1:0][CW-1:0]   grid_o,
  output logic [$clog2(ROWS+1)-1:0]           lines_o,
  output logic [15:0]                         total_lines_o,
  output logic [$clog2(MAX_LEVEL+1)-1:0]      level_o
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LW = $clog2(ROWS+1);
  localparam int VW = $clog2(MAX_LEVEL+1);

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   r_q;
  logic            row_full;
  logic [16:0]     tot_sum;
  logic [15:0]     tot_next;
  logic [15:0]     lvl_raw;
  logic [VW-1:0]   lvl_next;

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (grid_o[r_q][c] == '0) row_full = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE:  if (start_i) state_d = SCAN;
      SCAN: begin
        busy_o = 1'b1;
        if (row_full)       state_d = SHIFT;
        else if (r_q == '0) state_d = DONE;
      end
      SHIFT: begin
        busy_o  = 1'b1;
        state_d = SCAN;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Collapse keeps r unchanged so whatever drops into r is scanned again.
  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      grid_o  <= '0;
      r_q     <= '0;
      lines_o <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          grid_o  <= grid_i;
          r_q     <= RW'(ROWS-1);
          lines_o <= '0;
        end
        SCAN: if (!row_full && r_q != '0) r_q <= r_q - 1'b1;
        SHIFT: begin
          for (int i = ROWS-1; i > 0; i--) begin
            if (RW'(i) <= r_q) grid_o[i] <= grid_o[i-1];
          end
          grid_o[0] <= '0;
          lines_o   <= lines_o + LW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tot_sum  = {1'b0, total_lines_o} + 17'(lines_o);
    tot_next = tot_sum[16] ? 16'hFFFF : tot_sum[15:0];
    lvl_raw  = tot_next / 16'(LINES_PER_LEVEL);
    lvl_next = (lvl_raw > 16'(MAX_LEVEL)) ? VW'(MAX_LEVEL) : VW'(lvl_raw);
  end

  // A clear in the DONE cycle wins, discarding that pass's lines.
  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      total_lines_o <= '0;
      level_o       <= '0;
    end else if (clr_stats_i) begin
      total_lines_o <= '0;
      level_o       <= '0;
    end else if (state_q == DONE) begin
      total_lines_o <= tot_next;
      level_o       <= lvl_next;
    end
  end

endmodule
